// File: rtl/special_pair_gen.sv
// Operand-pair generator: streams LFSR-derived (in0,in1) pairs whose MSB/LSB
// equality check is forced to a requested outcome, over a valid/ready port.
module special_pair_gen #(
  parameter logic [15:0] SEED    = 16'hA5C3,
  parameter int          COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               cfg_match,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_in0,
  output logic [7:0]         out_in1,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  // An all-zero Galois LFSR would lock up, so a zero seed is bumped to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic {IDLE, GEN} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               hs;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] pair_in1(input logic [15:0] s, input logic m);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    a = s[15:8];
    b = s[7:0];
    if (m) begin
      r = {a[7], b[6:1], a[0]};
    end else if (b[7] == a[7] && b[0] == a[0]) begin
      r = {b[7:1], ~b[0]};
    end else begin
      r = b;
    end
    return r;
  endfunction

  assign hs = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    match_d = match_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_count != '0) begin
            state_d = GEN;
            rem_d   = cfg_count;
            match_d = cfg_match;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      GEN: begin
        if (hs) begin
          lfsr_d = lfsr_next(lfsr_q);
          rem_d  = rem_q - COUNT_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // The latched match flag only matters while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    match_q <= match_d;
  end

  assign out_valid = (state_q == GEN);
  assign busy      = out_valid;
  assign done      = done_q;
  assign out_last  = out_valid && (rem_q == COUNT_W'(1));
  assign out_in0   = out_valid ? lfsr_q[15:8] : 8'h00;
  assign out_in1   = out_valid ? pair_in1(lfsr_q, match_q) : 8'h00;

endmodule

// File: tb/tb_special_pair_gen.sv
// Directed bench for special_pair_gen: hand-computed pairs from SEED 16'hA5C3,
// handshake counting, last/done timing, start-in-GEN and mid-burst reset.
module tb_special_pair_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cfg_count;
  logic       cfg_match;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_in0;
  logic [7:0] out_in1;
  logic       out_last;
  logic       busy;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  seen_in0 [0:3];
  logic [7:0]  seen_in1 [0:3];

  special_pair_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_count(cfg_count),
    .cfg_match(cfg_match),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_in0  (out_in0),
    .out_in1  (out_in1),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_adv(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] m_in1(input logic [15:0] s, input logic m);
    logic [7:0] b;
    b = s[7:0];
    if (m) return {s[15], b[6:1], s[8]};
    if (b[7] == s[15] && b[0] == s[8]) return b ^ 8'h01;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; cfg_count = '0; cfg_match = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_lfsr = 16'hA5C3;
  endtask

  // Drives one burst and tallies handshakes, done pulses and rule violations.
  // rmode: 0 ready high, 1 random, 2 pattern 1,0,0. abort_hs>0 stops early.
  task automatic run_burst(input logic [7:0] cnt, input logic m, input int rmode,
                           input int abort_hs, input int start_cyc,
                           output int hs, output int dn, output int errs);
    logic       r;
    logic       hold;
    logic [7:0] h0, h1;
    bit         finished;
    start = 1'b1; cfg_count = cnt; cfg_match = m; out_ready = 1'b0;
    tick();
    start = 1'b0;
    hs = 0; dn = 0; errs = 0; hold = 1'b0; h0 = '0; h1 = '0; finished = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) dn++;
      if (abort_hs > 0 && hs == abort_hs) begin finished = 1'b1; break; end
      if (!out_valid && hs == int'(cnt)) begin finished = 1'b1; break; end
      if (cyc == start_cyc) begin start = 1'b1; cfg_count = 8'd9; cfg_match = ~m; end
      else start = 1'b0;
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 3 == 0);
      endcase
      out_ready = r;
      if (out_valid) begin
        if (hold && (out_in0 !== h0 || out_in1 !== h1)) errs++;
        if (out_in0 !== m_lfsr[15:8] || out_in1 !== m_in1(m_lfsr, m)) errs++;
        if (((out_in0[7] == out_in1[7]) && (out_in0[0] == out_in1[0])) !== m) errs++;
        if (out_last !== (hs == int'(cnt) - 1)) errs++;
        if (busy !== 1'b1) errs++;
        if (r) begin
          if (hs < 4) begin seen_in0[hs] = out_in0; seen_in1[hs] = out_in1; end
          hs++;
          m_lfsr = m_adv(m_lfsr);
          hold = 1'b0;
        end else begin
          hold = 1'b1; h0 = out_in0; h1 = out_in1;
        end
      end else begin
        errs++;
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!finished) errs++;
    if (abort_hs == 0) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        if (done) dn++;
        if (out_valid) errs++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; cfg_count = '0; cfg_match = 1'b0;
    tick();
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else pass_cnt++;
    total_cnt++; if ({out_in0, out_in1} !== 16'h0000) $display("FAIL reset_pair got %h want 0000", {out_in0, out_in1}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_match();
    do_reset();
    start = 1'b1; cfg_count = 8'd1; cfg_match = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t1_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_in0 !== 8'hA5) $display("FAIL t1_in0 got %h want a5", out_in0); else pass_cnt++;
    total_cnt++; if (out_in1 !== 8'hC3) $display("FAIL t1_in1 got %h want c3", out_in1); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b1) $display("FAIL t1_last got %b want 1", out_last); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL t1_early_done got %b want 0", done); else pass_cnt++;
    tick();
    total_cnt++; if ({out_valid, done, busy} !== 3'b010) $display("FAIL t1_end got valid/done/busy=%b want 010", {out_valid, done, busy}); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL t1_done_pulse got %b want 0", done); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_single_mismatch();
    do_reset();
    start = 1'b1; cfg_count = 8'd1; cfg_match = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (out_in0 !== 8'hA5) $display("FAIL t2_in0 got %h want a5", out_in0); else pass_cnt++;
    total_cnt++; if (out_in1 !== 8'hC2) $display("FAIL t2_in1 got %h want c2", out_in1); else pass_cnt++;
    tick();
    total_cnt++; if ({out_valid, done} !== 2'b01) $display("FAIL t2_end got valid/done=%b want 01", {out_valid, done}); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int hs, dn, errs;
    do_reset();
    run_burst(8'd4, 1'b1, 2, 0, -1, hs, dn, errs);
    total_cnt++; if (hs !== 4) $display("FAIL t3_handshakes got %0d want 4", hs); else pass_cnt++;
    total_cnt++; if (dn !== 1) $display("FAIL t3_done got %0d want 1", dn); else pass_cnt++;
    total_cnt++; if (errs !== 0) $display("FAIL t3_rules got %0d errors want 0", errs); else pass_cnt++;
    total_cnt++; if ({seen_in0[1], seen_in1[1]} !== 16'hE6E0) $display("FAIL t3_pair2 got %h want e6e0", {seen_in0[1], seen_in1[1]}); else pass_cnt++;
  endtask

  task automatic test_long_random();
    int hs, dn, errs;
    logic m;
    do_reset();
    m = 1'($urandom_range(0, 1));
    run_burst(8'd255, m, 1, 0, -1, hs, dn, errs);
    total_cnt++; if (hs !== 255) $display("FAIL t4_handshakes got %0d want 255", hs); else pass_cnt++;
    total_cnt++; if (dn !== 1) $display("FAIL t4_done got %0d want 1", dn); else pass_cnt++;
    total_cnt++; if (errs !== 0) $display("FAIL t4_rules got %0d errors want 0", errs); else pass_cnt++;
  endtask

  task automatic test_zero_and_start_in_gen();
    int hs, dn, errs;
    run_burst(8'd0, 1'b1, 0, 0, -1, hs, dn, errs);
    total_cnt++; if (hs !== 0) $display("FAIL t5_zero_pairs got %0d want 0", hs); else pass_cnt++;
    total_cnt++; if (dn !== 1 || errs !== 0) $display("FAIL t5_zero_done got done=%0d errs=%0d want 1/0", dn, errs); else pass_cnt++;
    run_burst(8'd3, 1'b0, 0, 0, 1, hs, dn, errs);
    total_cnt++; if (hs !== 3) $display("FAIL t5_start_in_gen got %0d want 3", hs); else pass_cnt++;
    total_cnt++; if (dn !== 1 || errs !== 0) $display("FAIL t5_gen_done got done=%0d errs=%0d want 1/0", dn, errs); else pass_cnt++;
  endtask

  task automatic test_abort();
    int hs, dn, errs, late_done;
    do_reset();
    run_burst(8'd5, 1'b1, 0, 2, -1, hs, dn, errs);
    total_cnt++; if (hs !== 2 || errs !== 0) $display("FAIL t6_pre got hs=%0d errs=%0d want 2/0", hs, errs); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL t6_drop got valid/busy=%b want 00", {out_valid, busy}); else pass_cnt++;
    late_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) late_done++;
      tick();
    end
    total_cnt++; if (late_done !== 0) $display("FAIL t6_no_done got %0d want 0", late_done); else pass_cnt++;
    start = 1'b1; cfg_count = 8'd1; cfg_match = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if ({out_valid, out_in0} !== 9'h1A5) $display("FAIL t6_reseed got valid/in0=%h want 1a5", {out_valid, out_in0}); else pass_cnt++;
    tick();
    out_ready = 1'b0;
    m_lfsr = m_adv(16'hA5C3);
  endtask

  task automatic test_back_to_back();
    int hs, dn, errs;
    run_burst(8'd2, 1'b0, 0, 0, -1, hs, dn, errs);
    run_burst(8'd3, 1'b1, 0, 0, -1, hs, dn, errs);
    total_cnt++; if (hs !== 3 || dn !== 1 || errs !== 0) $display("FAIL b2b got hs=%0d done=%0d errs=%0d want 3/1/0", hs, dn, errs); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_single_mismatch();
    test_stall();
    test_long_random();
    test_zero_and_start_in_gen();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
